// File: rtl/expr_tokenizer_if.sv
// Character-in / token-out stream bundle for expr_tokenizer.
//   in_char/in_valid/in_ready        : ASCII byte stream into the tokenizer
//   tok_*/tok_ready                  : typed token stream out of the tokenizer
// master = upstream/downstream environment, slave = tokenizer.
interface expr_tokenizer_if #(
  parameter int unsigned DATA_W = 32
);
  logic [7:0]        in_char;
  logic              in_valid;
  logic              in_ready;
  logic              tok_valid;
  logic              tok_ready;
  logic [2:0]        tok_type;
  logic [DATA_W-1:0] tok_value;
  logic              tok_last;

  modport master (
    output in_char, in_valid, tok_ready,
    input  in_ready, tok_valid, tok_type, tok_value, tok_last
  );

  modport slave (
    input  in_char, in_valid, tok_ready,
    output in_ready, tok_valid, tok_type, tok_value, tok_last
  );
endinterface

// File: rtl/expr_tokenizer.sv
// Byte-serial expression tokenizer: folds decimal digits into signed
// DATA_W-bit literals and emits NUM/ADD/MUL/LPAREN/RPAREN/END/ERR tokens.
//   clk, rst : clock, synchronous active-high reset
//   bus      : expr_tokenizer_if.slave (char stream in, token stream out)
module expr_tokenizer #(
  parameter int unsigned DATA_W = 32
) (
  input logic             clk,
  input logic             rst,
  expr_tokenizer_if.slave bus
);
  localparam int unsigned ACC_W = DATA_W + 4;
  localparam logic [ACC_W-1:0] MAG_MAX = {5'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {ST_SEP, ST_SIGN, ST_NUM, ST_DRAIN} state_e;
  typedef enum logic [2:0] {
    TK_NUM    = 3'd0,
    TK_ADD    = 3'd1,
    TK_MUL    = 3'd2,
    TK_LPAREN = 3'd3,
    TK_RPAREN = 3'd4,
    TK_ERR    = 3'd6,
    TK_END    = 3'd7
  } tok_e;

  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_SIGN    = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              tok_valid_q, tok_valid_d;
  tok_e              tok_type_q, tok_type_d;
  logic [DATA_W-1:0] tok_value_q, tok_value_d;
  logic              tok_last_q, tok_last_d;
  logic              pend_valid_q, pend_valid_d;
  tok_e              pend_type_q, pend_type_d;

  logic [7:0]        ch;
  logic              is_digit, is_minus, is_space, is_nul, is_op;
  tok_e              op_type;
  logic [ACC_W-1:0]  digit, acc_src;
  logic              ovf;
  logic [DATA_W-1:0] num_val;
  logic              in_ready;
  logic              accept;
  logic              out_free;

  logic [1:0]        n_tok;
  tok_e              t0_type, t1_type;
  logic [DATA_W-1:0] t0_value;
  logic              err;
  logic [1:0]        err_code;

  assign ch       = bus.in_char;
  assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_minus = (ch == 8'h2d);
  assign is_space = (ch == 8'h20);
  assign is_nul   = (ch == 8'h00);
  assign digit    = {{(ACC_W-4){1'b0}}, ch[3:0]};

  always_comb begin
    is_op   = 1'b1;
    op_type = TK_ADD;
    case (ch)
      8'h2b:   op_type = TK_ADD;
      8'h2a:   op_type = TK_MUL;
      8'h28:   op_type = TK_LPAREN;
      8'h29:   op_type = TK_RPAREN;
      default: is_op   = 1'b0;
    endcase
  end

  // acc*10 + d in NUM; a fresh literal starts from the digit alone.
  assign acc_src = (state_q == ST_NUM) ? ((acc_q << 3) + (acc_q << 1) + digit) : digit;
  assign ovf     = (acc_src > MAG_MAX);
  assign num_val = neg_q ? (-acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0];

  assign in_ready = !rst && !pend_valid_q && (!tok_valid_q || bus.tok_ready);
  assign accept   = bus.in_valid && in_ready;
  assign out_free = !tok_valid_q || bus.tok_ready;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    tok_valid_d  = tok_valid_q;
    tok_type_d   = tok_type_q;
    tok_value_d  = tok_value_q;
    tok_last_d   = tok_last_q;
    pend_valid_d = pend_valid_q;
    pend_type_d  = pend_type_q;
    n_tok        = 2'd0;
    t0_type      = TK_NUM;
    t0_value     = '0;
    t1_type      = TK_END;
    err          = 1'b0;
    err_code     = '0;

    if (accept) begin
      case (state_q)
        ST_SEP, ST_SIGN: begin
          if (is_digit) begin
            if (ovf) begin
              err      = 1'b1;
              err_code = ERR_OVF;
            end else begin
              acc_d   = acc_src;
              state_d = ST_NUM;
            end
          end else if (state_q == ST_SIGN) begin
            err      = 1'b1;
            err_code = ERR_SIGN;
          end else if (is_minus) begin
            neg_d   = 1'b1;
            state_d = ST_SIGN;
          end else if (is_op) begin
            n_tok   = 2'd1;
            t0_type = op_type;
          end else if (is_nul) begin
            n_tok   = 2'd1;
            t0_type = TK_END;
          end else if (!is_space) begin
            err      = 1'b1;
            err_code = ERR_ILLEGAL;
          end
        end
        ST_NUM: begin
          if (is_digit) begin
            if (ovf) begin
              err      = 1'b1;
              err_code = ERR_OVF;
            end else begin
              acc_d = acc_src;
            end
          end else if (is_space || is_op || is_nul) begin
            n_tok    = is_space ? 2'd1 : 2'd2;
            t0_type  = TK_NUM;
            t0_value = num_val;
            t1_type  = is_op ? op_type : TK_END;
            state_d  = ST_SEP;
            acc_d    = '0;
            neg_d    = 1'b0;
          end else begin
            err      = 1'b1;
            err_code = ERR_ILLEGAL;
          end
        end
        ST_DRAIN: begin
          if (is_nul) state_d = ST_SEP;
        end
        default: state_d = ST_SEP;
      endcase

      // An error on the terminator itself ends the expression; nothing to drain.
      if (err) begin
        n_tok    = 2'd1;
        t0_type  = TK_ERR;
        t0_value = {{(DATA_W-2){1'b0}}, err_code};
        state_d  = is_nul ? ST_SEP : ST_DRAIN;
        acc_d    = '0;
        neg_d    = 1'b0;
      end
    end

    // Acceptance implies a free output slot and an empty pending slot.
    if (out_free) begin
      if (pend_valid_q) begin
        tok_valid_d  = 1'b1;
        tok_type_d   = pend_type_q;
        tok_value_d  = '0;
        tok_last_d   = (pend_type_q == TK_END);
        pend_valid_d = 1'b0;
      end else if (n_tok != 2'd0) begin
        tok_valid_d = 1'b1;
        tok_type_d  = t0_type;
        tok_value_d = t0_value;
        tok_last_d  = (t0_type == TK_END) || (t0_type == TK_ERR);
        if (n_tok == 2'd2) begin
          pend_valid_d = 1'b1;
          pend_type_d  = t1_type;
        end
      end else begin
        tok_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SEP;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      tok_valid_q  <= 1'b0;
      tok_type_q   <= TK_NUM;
      tok_value_q  <= '0;
      tok_last_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_type_q  <= TK_NUM;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      tok_valid_q  <= tok_valid_d;
      tok_type_q   <= tok_type_d;
      tok_value_q  <= tok_value_d;
      tok_last_q   <= tok_last_d;
      pend_valid_q <= pend_valid_d;
      pend_type_q  <= pend_type_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.tok_valid = tok_valid_q;
  assign bus.tok_type  = tok_type_q;
  assign bus.tok_value = tok_value_q;
  assign bus.tok_last  = tok_last_q;
endmodule

// File: tb/tb_expr_tokenizer.sv
// Directed bench for expr_tokenizer at DATA_W=8. In stimulus strings '$'
// stands for the NUL terminator.
module tb_expr_tokenizer;
  localparam int unsigned W = 8;
  localparam logic [2:0] T_NUM = 3'd0, T_ADD = 3'd1, T_MUL = 3'd2, T_LP = 3'd3,
                         T_RP = 3'd4, T_ERR = 3'd6, T_END = 3'd7;

  typedef struct packed {
    logic [2:0]   typ;
    logic [W-1:0] val;
    logic         last;
  } tok_t;

  typedef struct {
    string       text;
    int unsigned n;
    tok_t [7:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  expr_tokenizer_if #(.DATA_W(W)) bus ();
  expr_tokenizer #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned stall_checks = 0;
  tok_t        got_q[$];
  logic        stall_prev = 1'b0;
  tok_t        held = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic tok_t cur_tok();
    return {bus.tok_type, bus.tok_value, bus.tok_last};
  endfunction

  function automatic tok_t tk(input logic [2:0] typ, input int v = 0);
    tok_t r;
    r.typ  = typ;
    r.val  = v[W-1:0];
    r.last = (typ == T_ERR) || (typ == T_END);
    return r;
  endfunction

  function automatic vec_t mk(input string t, input int unsigned n,
                              input tok_t a0 = '0, input tok_t a1 = '0,
                              input tok_t a2 = '0, input tok_t a3 = '0,
                              input tok_t a4 = '0, input tok_t a5 = '0,
                              input tok_t a6 = '0, input tok_t a7 = '0);
    vec_t v;
    v.text = t;
    v.n    = n;
    v.exp  = {a7, a6, a5, a4, a3, a2, a1, a0};
    return v;
  endfunction

  function automatic logic [7:0] map_ch(input byte c);
    return (c == 8'h24) ? 8'h00 : c;
  endfunction

  // Token collector and output-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (stall_prev && !rst) begin
      check("hold tok_valid", 64'(bus.tok_valid), 64'd1);
      check("hold tok fields", 64'(cur_tok()), 64'(held));
      stall_checks++;
    end
    if (!rst && bus.tok_valid && !bus.tok_ready)
      check("in_ready under backpressure", 64'(bus.in_ready), 64'd0);
    if (!rst && bus.tok_valid && bus.tok_ready)
      got_q.push_back(cur_tok());
    stall_prev <= !rst && bus.tok_valid && !bus.tok_ready;
    held       <= cur_tok();
  end

  task automatic send_char(input logic [7:0] c, output int unsigned waits);
    waits = 0;
    bus.in_char  = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready timeout: got 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    int unsigned w;
    for (int i = 0; i < s.len(); i++) send_char(map_ch(s[i]), w);
  endtask

  task automatic compare_vec(input string tag, input vec_t v);
    check({tag, " count"}, 64'(got_q.size()), 64'(v.n));
    for (int k = 0; k < int'(v.n); k++)
      if (k < got_q.size())
        check($sformatf("%s tok%0d", tag, k), 64'(got_q[k]), 64'(v.exp[k]));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    got_q.delete();
    send_str(v.text);
    repeat (4) @(posedge clk);
    #1;
    compare_vec(tag, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    vec_t        s1;
    int unsigned w;
    int unsigned g;
    int unsigned base;
    int unsigned exp_w[7];

    bus.in_valid  = 1'b0;
    bus.in_char   = 8'h00;
    bus.tok_ready = 1'b1;

    s1 = mk("12+3*4$", 6, tk(T_NUM, 12), tk(T_ADD), tk(T_NUM, 3), tk(T_MUL),
            tk(T_NUM, 4), tk(T_END));
    exp_w = '{0, 0, 0, 1, 0, 1, 0};

    tbl.push_back(mk("(-7 )*( 20)$", 8, tk(T_LP), tk(T_NUM, -7), tk(T_RP), tk(T_MUL),
                     tk(T_LP), tk(T_NUM, 20), tk(T_RP), tk(T_END)));
    tbl.push_back(mk("$", 1, tk(T_END)));
    tbl.push_back(mk("127$", 2, tk(T_NUM, 127), tk(T_END)));
    tbl.push_back(mk("-127$", 2, tk(T_NUM, -127), tk(T_END)));
    tbl.push_back(mk("128+1$", 1, tk(T_ERR, 3)));
    tbl.push_back(mk("5$", 2, tk(T_NUM, 5), tk(T_END)));
    tbl.push_back(mk("1+/2$", 3, tk(T_NUM, 1), tk(T_ADD), tk(T_ERR, 1)));
    tbl.push_back(mk("9$", 2, tk(T_NUM, 9), tk(T_END)));
    tbl.push_back(mk("- 4$", 1, tk(T_ERR, 2)));
    tbl.push_back(mk("9$", 2, tk(T_NUM, 9), tk(T_END)));
    tbl.push_back(mk("3-4$", 1, tk(T_ERR, 1)));
    tbl.push_back(mk("9$", 2, tk(T_NUM, 9), tk(T_END)));
    tbl.push_back(mk("-$", 1, tk(T_ERR, 2)));
    tbl.push_back(mk("9$", 2, tk(T_NUM, 9), tk(T_END)));
    tbl.push_back(mk("007$", 2, tk(T_NUM, 7), tk(T_END)));
    tbl.push_back(mk(")5(++$", 6, tk(T_RP), tk(T_NUM, 5), tk(T_LP), tk(T_ADD),
                     tk(T_ADD), tk(T_END)));
    tbl.push_back(mk("12 34$", 3, tk(T_NUM, 12), tk(T_NUM, 34), tk(T_END)));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset tok_valid", 64'(bus.tok_valid), 64'd0);
    check("reset tok_type", 64'(bus.tok_type), 64'd0);
    check("reset tok_value", 64'(bus.tok_value), 64'd0);
    check("reset tok_last", 64'(bus.tok_last), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;

    // Stream 1 with free-running tok_ready: latency and one-cycle stalls
    got_q.delete();
    for (int i = 0; i < 7; i++) begin
      send_char(map_ch(s1.text[i]), w);
      check($sformatf("t1 stall before char%0d", i), 64'(w), 64'(exp_w[i]));
      if (i == 2) begin
        check("t1 NUM12 valid after +", 64'(bus.tok_valid), 64'd1);
        check("t1 NUM12 type", 64'(bus.tok_type), 64'(T_NUM));
        check("t1 NUM12 value", 64'(bus.tok_value), 64'd12);
        check("t1 in_ready low after +", 64'(bus.in_ready), 64'd0);
      end
    end
    check("t1 in_ready low after NUL", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("t1 in_ready back after NUL", 64'(bus.in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    compare_vec("t1", s1);

    // Table-driven expressions
    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Stream 1 with a 5-cycle tok_ready stall mid-stream
    got_q.delete();
    base = stall_checks;
    fork
      send_str(s1.text);
      begin
        g = 0;
        @(negedge clk);
        while (!bus.tok_valid && g < 100) begin
          g++;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.tok_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.tok_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    compare_vec("t3", s1);
    check("t3 stall cycles observed", 64'((stall_checks - base) >= 4), 64'd1);

    // Reset in the middle of a literal
    got_q.delete();
    send_str("45");
    rst = 1'b1;
    @(negedge clk);
    check("t6 in_ready during rst", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6 tok_valid after rst", 64'(bus.tok_valid), 64'd0);
    check("t6 no tokens from partial literal", 64'(got_q.size()), 64'd0);
    run_vec("t6", mk("6$", 2, tk(T_NUM, 6), tk(T_END)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/expr_tokenizer.md
# expr_tokenizer

Byte-serial front end for the stack-based calculator: accepts a stream of ASCII expression characters and emits typed tokens (signed integer literals, `+`, `*`, `(`, `)`, end-of-expression, error). Decimal digits are folded into one signed `DATA_W`-bit literal. The block sits directly upstream of the infix-to-postfix/evaluation stage and replaces its fixed-length character vector with a valid/ready token stream.

## Interface

- `DATA_W`, default 32: literal width, two's complement.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_char` input 8: ASCII character.
- `in_valid` input 1: `in_char` is valid.
- `in_ready` output 1: the character is accepted on a cycle where `in_valid && in_ready`.
- `tok_valid` output 1: the token outputs are valid.
- `tok_ready` input 1: the downstream stage takes the token on a cycle where `tok_valid && tok_ready`.
- `tok_type` output 3: token type.
  - 0 = NUM
  - 1 = ADD
  - 2 = MUL
  - 3 = LPAREN
  - 4 = RPAREN
  - 6 = ERR
  - 7 = END
- `tok_value` output `DATA_W`:
  - NUM: the signed literal.
  - ERR: the error code.
  - All other types: 0.
- `tok_last` output 1: set with END and ERR tokens only.

## Operation

**Character classes**
- `0`–`9`: digit.
- `-`: sign prefix only. There is no subtraction.
- space: separator.
- `+` `*` `(` `)`: operator tokens.
- 0x00 (NUL): expression terminator.
- Anything else: illegal.

**FSM states**
- SEP (reset state):
  - digit: load the accumulator, go to NUM.
  - `-`: set the sign, go to SIGN.
  - operator: emit its token.
  - NUL: emit END.
  - space: ignored.
  - illegal: ERR code 1.
- SIGN:
  - digit: load the accumulator, go to NUM.
  - any other character, including space and NUL: ERR code 2.
- NUM:
  - digit: `acc = acc*10 + d`.
  - space: emit NUM, go to SEP.
  - operator: emit NUM, then the operator token (two tokens), go to SEP.
  - NUL: emit NUM, then END (two tokens), go to SEP.
  - `-`: illegal, ERR code 1.
  - illegal: ERR code 1.
- DRAIN:
  - Entered after an ERR token is queued.
  - Discards all characters up to and including the next NUL, then returns to SEP.
  - No END token is emitted for an errored expression.

**Arithmetic**
- The accumulator holds a magnitude, at least `DATA_W+4` bits wide.
- The emitted value is the magnitude, negated when the sign is set.
- Overflow, ERR code 3: magnitude > 2^(DATA_W-1)-1. The limit is the same for both signs, so the most negative value is not representable.
- Overflow is detected on the digit that causes it.
- Leading zeros are legal; `007` gives 7.

**Errors**
- The partially accumulated literal is discarded, not emitted.
- Tokens already emitted for the same expression remain valid.

**Grammar**
- Not checked here. `)5(` and `++` tokenize without error.

**Buffering**
- One output register plus one pending register; at most two tokens are produced per accepted character.
- `in_ready = !rst && !pend_valid && (!tok_valid || tok_ready)`.
- When a character produces two tokens:
  - The first goes to the output register.
  - The second goes to the pending register.
  - The pending token moves into the output register on the cycle the output handshakes.

## Timing

**Reset**
- Effective at the clock edge while `rst=1`.
- Reset values: `tok_valid=0`, `tok_type=0`, `tok_value=0`, `tok_last=0`, pending register empty, state SEP, accumulator and sign cleared.
- `in_ready=0` while `rst=1`.
- Reset mid-expression discards all partial and queued tokens.

**Latency**
- A token is visible with `tok_valid=1` the cycle after the character that completes it is accepted.
- A NUM token completes on its terminating character, not on its last digit.
- A second (pending) token appears the cycle after the first handshakes.

**Throughput**
- With `tok_ready` held at 1: one character per cycle.
- After a two-token character, `in_ready` drops for exactly one cycle.
- Digits and spaces produce no token and never stall while the output path is free.

**Output stability**
- While `tok_valid && !tok_ready`, `tok_type`, `tok_value` and `tok_last` hold stable.
- `tok_valid` never deasserts without a handshake, except on reset.

**Input rules**
- `in_char` is sampled only on acceptance.
- `in_valid` may toggle freely and has no effect when `in_ready=0`.

## Test plan

1. "12+3*4\0", `tok_ready=1` -> NUM 12, ADD, NUM 3, MUL, NUM 4, END (`tok_last=1`). NUM 12 appears the cycle after `+` is accepted; `in_ready` is low for one cycle after `+`, `*` and NUL.
2. "(-7 )*( 20)\0" -> LPAREN, NUM -7, RPAREN, MUL, LPAREN, NUM 20, RPAREN, END. "\0" alone -> END only.
3. Stream 1 with `tok_ready` low for 5 cycles mid-stream -> `in_ready` low within one accepted character, token fields stable, identical token sequence with no loss or duplication.
4. `DATA_W=8`:
   - "127\0" -> NUM 127, END.
   - "-127\0" -> NUM -127.
   - "128+1\0" -> ERR 3 (`tok_last=1`), `+1\0` discarded, no END.
   - Then "5\0" -> NUM 5, END.
5. Error handling:
   - "1+/2\0" -> NUM 1, ADD, ERR 1.
   - "- 4\0" -> ERR 2.
   - "3-4\0" -> ERR 1.
   - "-\0" -> ERR 2.
   - After each case, the next expression "9\0" -> NUM 9, END.
6. Reset mid-literal: accept "45", assert `rst` for 1 cycle -> no tokens emitted, `tok_valid=0`. Then "6\0" -> NUM 6, END.
